mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF stage (instruction reads) and
//  the MEM stage (data loads/stores). Data requests win by default. A starvation counter

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between IF reads and MEM-stage loads/stores.
// Data wins by default; a starvation counter forces an IF grant after a run of data grants.
module mem_port_arbiter #(
  parameter int          ADDR_W     = 16,
  parameter int          DATA_W     = 32,
  parameter int          MEM_LAT    = 1,
  parameter int          STARVE_MAX = 4,
  parameter logic [1:0]  WORD_SEL   = 2'b00
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_adr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_adr_i,
  input  logic [DATA_W-1:0] dm_wd_i,
  input  logic [1:0]        dm_sel_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  output logic [1:0]        mem_sel_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_dm_o
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAT  = CNT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] SMAX = STV_W'(STARVE_MAX);

  typedef enum logic { ST_IDLE, ST_WAIT } state_t;
  typedef enum logic { OWN_IF,  OWN_DM  } owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;

  logic resp;
  logic gnt_ok;
  logic pick_if;
  logic if_gnt;
  logic dm_gnt;

  // Grant decision: legal in IDLE or on the response cycle of an access.
  always_comb begin
    resp    = (state_q == ST_WAIT) && (cnt_q == LAT);
    gnt_ok  = (state_q == ST_IDLE) || resp;
    pick_if = if_req_i && (!dm_req_i || (starve_q == SMAX));
    if_gnt  = gnt_ok && pick_if;
    dm_gnt  = gnt_ok && dm_req_i && !pick_if;
  end

  // Next-state: latency tracking, ownership and starvation counting.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    unique case (state_q)
      ST_IDLE: begin
        if (if_gnt || dm_gnt) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
          owner_d = if_gnt ? OWN_IF : OWN_DM;
        end
      end
      ST_WAIT: begin
        if (!resp) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (if_gnt || dm_gnt) begin
          cnt_d   = CNT_W'(1);
          owner_d = if_gnt ? OWN_IF : OWN_DM;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!if_req_i || if_gnt) begin
      starve_d = '0;
    end else if (dm_gnt && (starve_q != SMAX)) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IF;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  // Outputs: memory mux from the winner, responses to the owner, all zero in reset.
  always_comb begin
    if_gnt_o    = 1'b0;
    dm_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    dm_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    dm_rdata_o  = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_adr_o   = '0;
    mem_wd_o    = '0;
    mem_sel_o   = 2'b00;
    stall_if_o  = 1'b0;
    stall_dm_o  = 1'b0;
    if (rst_i) begin
      if_gnt_o   = if_gnt;
      dm_gnt_o   = dm_gnt;
      stall_if_o = if_req_i && !if_gnt;
      stall_dm_o = dm_req_i && !dm_gnt;
      if (if_gnt) begin
        mem_en_o  = 1'b1;
        mem_adr_o = if_adr_i;
        mem_sel_o = WORD_SEL;
      end else if (dm_gnt) begin
        mem_en_o  = 1'b1;
        mem_we_o  = dm_we_i;
        mem_adr_o = dm_adr_i;
        mem_wd_o  = dm_wd_i;
        mem_sel_o = dm_sel_i;
      end
      if (resp && (owner_q == OWN_IF)) begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_rdata_i;
      end
      if (resp && (owner_q == OWN_DM)) begin
        dm_rvalid_o = 1'b1;
        dm_rdata_o  = mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=1 instance driven from a vector
// table and a MEM_LAT=3 instance exercised by hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_adr;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_adr;
  logic [31:0] dm_wd;
  logic [1:0]  dm_sel;
  logic [31:0] mem_rdata;

  logic        a_if_gnt, a_if_rv, a_dm_gnt, a_dm_rv, a_en, a_we, a_sif, a_sdm;
  logic [31:0] a_if_rd, a_dm_rd, a_wd;
  logic [15:0] a_adr;
  logic [1:0]  a_sel;

  logic        b_if_gnt, b_if_rv, b_dm_gnt, b_dm_rv, b_en, b_we, b_sif, b_sdm;
  logic [31:0] b_if_rd, b_dm_rd, b_wd;
  logic [15:0] b_adr;
  logic [1:0]  b_sel;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_adr_i(if_adr),
    .if_gnt_o(a_if_gnt), .if_rvalid_o(a_if_rv), .if_rdata_o(a_if_rd),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_adr_i(dm_adr),
    .dm_wd_i(dm_wd), .dm_sel_i(dm_sel),
    .dm_gnt_o(a_dm_gnt), .dm_rvalid_o(a_dm_rv), .dm_rdata_o(a_dm_rd),
    .mem_en_o(a_en), .mem_we_o(a_we), .mem_adr_o(a_adr),
    .mem_wd_o(a_wd), .mem_sel_o(a_sel), .mem_rdata_i(mem_rdata),
    .stall_if_o(a_sif), .stall_dm_o(a_sdm)
  );

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_lat3 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_adr_i(if_adr),
    .if_gnt_o(b_if_gnt), .if_rvalid_o(b_if_rv), .if_rdata_o(b_if_rd),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_adr_i(dm_adr),
    .dm_wd_i(dm_wd), .dm_sel_i(dm_sel),
    .dm_gnt_o(b_dm_gnt), .dm_rvalid_o(b_dm_rv), .dm_rdata_o(b_dm_rd),
    .mem_en_o(b_en), .mem_we_o(b_we), .mem_adr_o(b_adr),
    .mem_wd_o(b_wd), .mem_sel_o(b_sel), .mem_rdata_i(mem_rdata),
    .stall_if_o(b_sif), .stall_dm_o(b_sdm)
  );

  typedef struct {
    logic        rst, ifr, dmr;
    logic [31:0] mrd;
    logic        e_ifg, e_ifv, e_dmg, e_dmv;
  } vec_t;

  localparam int NV = 21;
  vec_t tv [NV];

  function automatic vec_t mk(input logic r, input logic i, input logic d,
                              input logic [31:0] m, input logic ig,
                              input logic iv, input logic dg, input logic dv);
    vec_t v;
    v.rst = r; v.ifr = i; v.dmr = d; v.mrd = m;
    v.e_ifg = ig; v.e_ifv = iv; v.e_dmg = dg; v.e_dmv = dv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic i, input logic d,
                       input logic we, input logic [15:0] da,
                       input logic [31:0] wd, input logic [31:0] m);
    @(negedge clk);
    rst = r; if_req = i; dm_req = d; dm_we = we;
    dm_adr = da; dm_wd = wd; mem_rdata = m;
    #1;
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_adr = 16'h0004; dm_adr = 16'h0020; dm_wd = 32'h1111_1111;
    dm_sel = 2'b10; mem_rdata = '0;

    tv[0]  = mk(0, 1, 1, 32'h0,         0, 0, 0, 0);
    tv[1]  = mk(0, 1, 1, 32'h0,         0, 0, 0, 0);
    tv[2]  = mk(1, 1, 1, 32'hAAAA_0001, 0, 0, 1, 0);
    tv[3]  = mk(1, 1, 1, 32'hAAAA_0002, 0, 0, 1, 1);
    tv[4]  = mk(1, 1, 1, 32'hAAAA_0003, 0, 0, 1, 1);
    tv[5]  = mk(1, 1, 1, 32'hAAAA_0004, 0, 0, 1, 1);
    tv[6]  = mk(1, 1, 1, 32'hAAAA_0005, 1, 0, 0, 1);
    tv[7]  = mk(1, 0, 0, 32'h1234_5678, 0, 1, 0, 0);
    tv[8]  = mk(1, 0, 0, 32'h0000_0055, 0, 0, 0, 0);
    tv[9]  = mk(1, 1, 1, 32'hBBBB_0001, 0, 0, 1, 0);
    tv[10] = mk(1, 1, 1, 32'hBBBB_0002, 0, 0, 1, 1);
    tv[11] = mk(1, 1, 1, 32'hBBBB_0003, 0, 0, 1, 1);
    tv[12] = mk(1, 0, 1, 32'hBBBB_0004, 0, 0, 1, 1);
    tv[13] = mk(1, 1, 1, 32'hBBBB_0005, 0, 0, 1, 1);
    tv[14] = mk(1, 1, 1, 32'hBBBB_0006, 0, 0, 1, 1);
    tv[15] = mk(1, 1, 1, 32'hBBBB_0007, 0, 0, 1, 1);
    tv[16] = mk(1, 1, 1, 32'hBBBB_0008, 0, 0, 1, 1);
    tv[17] = mk(1, 1, 1, 32'hBBBB_0009, 1, 0, 0, 1);
    tv[18] = mk(1, 0, 0, 32'hCCCC_0001, 0, 1, 0, 0);
    tv[19] = mk(1, 1, 0, 32'hCCCC_0002, 1, 0, 0, 0);
    tv[20] = mk(1, 0, 0, 32'hCAFE_F00D, 0, 1, 0, 0);

    for (int i = 0; i < NV; i++) begin
      logic [15:0] e_adr;
      logic [31:0] e_wd;
      logic [1:0]  e_sel;
      drive(tv[i].rst, tv[i].ifr, tv[i].dmr, 1'b0, 16'h0020,
            32'h1111_1111, tv[i].mrd);
      e_adr = tv[i].e_ifg ? 16'h0004 : (tv[i].e_dmg ? 16'h0020 : 16'h0);
      e_wd  = tv[i].e_dmg ? 32'h1111_1111 : 32'h0;
      e_sel = tv[i].e_dmg ? 2'b10 : 2'b00;
      chk($sformatf("v%0d if_gnt", i), 32'(a_if_gnt), 32'(tv[i].e_ifg));
      chk($sformatf("v%0d dm_gnt", i), 32'(a_dm_gnt), 32'(tv[i].e_dmg));
      chk($sformatf("v%0d if_rv", i), 32'(a_if_rv), 32'(tv[i].e_ifv));
      chk($sformatf("v%0d dm_rv", i), 32'(a_dm_rv), 32'(tv[i].e_dmv));
      chk($sformatf("v%0d if_rd", i), a_if_rd,
          tv[i].e_ifv ? tv[i].mrd : 32'h0);
      chk($sformatf("v%0d dm_rd", i), a_dm_rd,
          tv[i].e_dmv ? tv[i].mrd : 32'h0);
      chk($sformatf("v%0d mem_en", i), 32'(a_en),
          32'(tv[i].e_ifg | tv[i].e_dmg));
      chk($sformatf("v%0d mem_we", i), 32'(a_we), 32'h0);
      chk($sformatf("v%0d mem_adr", i), 32'(a_adr), 32'(e_adr));
      chk($sformatf("v%0d mem_wd", i), a_wd, e_wd);
      chk($sformatf("v%0d mem_sel", i), 32'(a_sel), 32'(e_sel));
      chk($sformatf("v%0d stall_if", i), 32'(a_sif),
          32'(tv[i].rst & tv[i].ifr & ~tv[i].e_ifg));
      chk($sformatf("v%0d stall_dm", i), 32'(a_sdm),
          32'(tv[i].rst & tv[i].dmr & ~tv[i].e_dmg));
    end

    // MEM_LAT=3: store with IF pending; next grant only on the response cycle.
    drive(0, 0, 0, 0, 16'h0, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 16'h0, 32'h0, 32'h0);
    drive(1, 1, 1, 1, 16'h0010, 32'hDEAD_BEEF, 32'h0);
    chk("st t dm_gnt", 32'(b_dm_gnt), 32'h1);
    chk("st t if_gnt", 32'(b_if_gnt), 32'h0);
    chk("st t mem_we", 32'(b_we), 32'h1);
    chk("st t mem_adr", 32'(b_adr), 32'h0010);
    chk("st t mem_wd", b_wd, 32'hDEAD_BEEF);
    chk("st t stall_if", 32'(b_sif), 32'h1);
    for (int k = 1; k <= 2; k++) begin
      drive(1, 1, 0, 0, 16'h0, 32'h0, 32'h0);
      chk($sformatf("st t+%0d if_gnt", k), 32'(b_if_gnt), 32'h0);
      chk($sformatf("st t+%0d mem_en", k), 32'(b_en), 32'h0);
      chk($sformatf("st t+%0d mem_we", k), 32'(b_we), 32'h0);
      chk($sformatf("st t+%0d dm_rv", k), 32'(b_dm_rv), 32'h0);
      chk($sformatf("st t+%0d stall_if", k), 32'(b_sif), 32'h1);
    end
    drive(1, 1, 0, 0, 16'h0, 32'h0, 32'h0BAD_F00D);
    chk("st t+3 dm_rv", 32'(b_dm_rv), 32'h1);
    chk("st t+3 if_gnt", 32'(b_if_gnt), 32'h1);
    chk("st t+3 mem_we", 32'(b_we), 32'h0);
    chk("st t+3 mem_adr", 32'(b_adr), 32'h0004);
    chk("st t+3 stall_if", 32'(b_sif), 32'h0);
    drive(1, 0, 0, 0, 16'h0, 32'h0, 32'h0);
    chk("if t+1 if_rv", 32'(b_if_rv), 32'h0);
    drive(1, 0, 0, 0, 16'h0, 32'h0, 32'h0);
    chk("if t+2 if_rv", 32'(b_if_rv), 32'h0);
    drive(1, 0, 0, 0, 16'h0, 32'h0, 32'h7777_0001);
    chk("if t+3 if_rv", 32'(b_if_rv), 32'h1);
    chk("if t+3 if_rd", b_if_rd, 32'h7777_0001);
    chk("if t+3 dm_rv", 32'(b_dm_rv), 32'h0);

    // MEM_LAT=3: reset during an in-flight load drops it.
    drive(1, 0, 1, 0, 16'h0030, 32'h0, 32'h0);
    chk("rs t dm_gnt", 32'(b_dm_gnt), 32'h1);
    drive(0, 1, 1, 0, 16'h0030, 32'h0, 32'h5A5A_5A5A);
    chk("rs t+1 mem_en", 32'(b_en), 32'h0);
    chk("rs t+1 stall_if", 32'(b_sif), 32'h0);
    chk("rs t+1 stall_dm", 32'(b_sdm), 32'h0);
    drive(1, 1, 0, 0, 16'h0, 32'h0, 32'h5A5A_5A5A);
    chk("rs t+2 if_gnt", 32'(b_if_gnt), 32'h1);
    chk("rs t+2 dm_rv", 32'(b_dm_rv), 32'h0);
    drive(1, 0, 0, 0, 16'h0, 32'h0, 32'h5A5A_5A5A);
    chk("rs t+3 dm_rv", 32'(b_dm_rv), 32'h0);
    chk("rs t+3 dm_rd", b_dm_rd, 32'h0);
    chk("rs t+3 if_rv", 32'(b_if_rv), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
